rv523_shift_seq: RTL
====================

// Module: rv523_shift_seq
// PURPOSE
//  Multi-cycle RV32 shift unit (SLL/SRL/SRA) for the RV523 discrete-cell datapath.
//  Sits downstream of the NOT/NAND/NOR/AOI/OAI cell library: the netlist maps onto those cells plus DFFs.
//  Iterative stepping replaces a barrel shifter to cut cell count.
//  Takes operands from the execute stage over valid/ready and returns the result over valid/ready.
// PARAMETERS
//  XLEN    32              datapath width; power of two, >= 8
//  SHW     $clog2(XLEN)    shift-amount width (derived; do not override)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      operand strobe
//  in_ready    out  1      unit can accept (high only in IDLE)
//  in_op       in   2      00=SLL, 01=SRL, 11=SRA, 10=SLL (alias)
//  in_data     in   XLEN   value to shift
//  in_shamt    in   SHW    shift amount 0..XLEN-1
//  out_valid   out  1      result available (high only in DONE)
//  out_ready   in   1      consumer takes result
//  out_data    out  XLEN   shifted result; held stable while out_valid
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, cnt=0.
//   Mid-operation reset discards the operation; no output is produced for it.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:  in_valid&in_ready at edge: load acc=in_data, cnt=in_shamt, op.
//          Go to DONE if in_shamt==0, else go to SHIFT.
//   SHIFT: one step per edge.
//          SLL: acc<<1, zero fill. SRL: acc>>1, zero fill. SRA: acc>>1, acc[XLEN-1] fill.
//          cnt decrements by the step size. Go to DONE when the post-step cnt==0.
//   DONE:  out_valid=1, out_data=acc. out_ready at edge -> IDLE.
//          in_ready stays 0 in DONE; there is no same-cycle accept/return bypass.
//  Latency: accept edge to first out_valid cycle = steps+1 edges. steps = in_shamt without the option.
//  Back-pressure: out_ready low holds DONE indefinitely; out_data must not change.
//  in_valid while in_ready=0 is ignored; the upstream stage holds its operands.
//  in_op/in_data/in_shamt are sampled only at the accept edge; later changes have no effect.
//  cnt is SHW bits wide, so no wrap: the maximum shamt XLEN-1 fits exactly.
//  busy = (state != IDLE), combinational from the state register.
// CONFIGURATION
//  RV523_SHIFT4_EN defined:
//   SHIFT steps by 4 (same fill rules) while cnt>=4, then by 1.
//   steps = floor(shamt/4) + shamt%4.
//  RV523_SHIFT4_EN undefined:
//   1-bit steps only; the 4-bit step mux and cnt>=4 compare are absent from the netlist.
//  Port list and handshake are identical in both builds.
// TESTING
//  1. Reset mid-SHIFT (SLL 0x1, shamt 20, rst_n low at step 5) -> IDLE next cycle,
//     in_ready=1, out_valid never pulses, out_data=0.
//  2. SLL 0x0000_0001, shamt 31, out_ready=1 -> out_data=0x8000_0000.
//     out_valid at edge 32 (base build) or edge 11 (SHIFT4).
//  3. SRA 0x8000_00F0, shamt 4 -> 0xF800_000F.
//     SRL same operands -> 0x0800_000F.
//  4. shamt 0, op SRA, data 0xDEAD_BEEF -> out_valid one edge after accept, out_data=0xDEAD_BEEF.
//  5. SRL 0xFFFF_FFFF shamt 8, out_ready low for 10 cycles after out_valid ->
//     out_data holds 0x00FF_FFFF, in_ready=0 throughout. One accept per result.
//  6. Back-to-back: in_valid held high with a new operand after completion ->
//     second accept only on the edge after DONE->IDLE. in_op=10 shifts left.

Source files
------------

// File: rtl/rv523_shift_seq.sv
// rv523_shift_seq: iterative RV32 SLL/SRL/SRA unit; one shift step per clock. Build option: RV523_SHIFT4_EN (4-bit steps while cnt>=4).
// Latency: accept edge to first out_valid cycle = steps+1 edges (steps = shamt, or shamt/4 + shamt%4 with RV523_SHIFT4_EN).
// Backpressure: in_ready only in IDLE; DONE holds out_valid/out_data stable until out_ready.
module rv523_shift_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_data,
    input  logic [SHW-1:0]  in_shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_step;
    logic [SHW-1:0]  cnt;
    logic [SHW-1:0]  cnt_step;
    logic            shift_right;
    logic            shift_arith;
    logic            fill;

    // Vacated bits take the sign bit only for SRA; SLL/SRL zero fill.
    assign fill = shift_arith & acc[XLEN-1];

`ifdef RV523_SHIFT4_EN
    logic step4;
    assign step4 = (cnt >= SHW'(4));

    always_comb begin
        if (step4) begin
            cnt_step = cnt - SHW'(4);
            acc_step = shift_right ? {{4{fill}}, acc[XLEN-1:4]} : {acc[XLEN-5:0], 4'b0000};
        end else begin
            cnt_step = cnt - SHW'(1);
            acc_step = shift_right ? {fill, acc[XLEN-1:1]} : {acc[XLEN-2:0], 1'b0};
        end
    end
`else
    always_comb begin
        cnt_step = cnt - SHW'(1);
        acc_step = shift_right ? {fill, acc[XLEN-1:1]} : {acc[XLEN-2:0], 1'b0};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            shift_right <= 1'b0;
            shift_arith <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc         <= in_data;
                        cnt         <= in_shamt;
                        shift_right <= in_op[0];
                        shift_arith <= &in_op;
                        in_ready    <= 1'b0;
                        if (in_shamt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_step;
                    cnt <= cnt_step;
                    if (cnt_step == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // acc is only written in IDLE/SHIFT, so it is frozen while DONE presents it.
    assign out_data = acc;
    assign busy     = (state != IDLE);

endmodule
